kmer_window_streamer: RTL and testbench
=======================================

// Module: kmer_window_streamer
// PURPOSE
//  Front-end of the hasher: converts a packed genome byte stream into sliding k-mers with start indices.
//  Parametrised successor to the fixed KMER_LEN/BASE_LEN front end. Adds runtime stride, sequence framing and backpressure.
//  Sits between the FM read path (sequence bytes) and the hasher (one k-mer per handshake).
// PARAMETERS
//  WORD_W   8   input word width in bits (GENOME_BTYE); must be a multiple of BASE_W
//  BASE_W   4   bits per base (BASE_LEN)
//  KMER_LEN 4   bases per k-mer; must be >= 2
//  IDX_W    16  width of k-mer start index; wraps modulo 2^IDX_W
//  derived  BPW = WORD_W/BASE_W (bases per word); KMER_W = KMER_LEN*BASE_W
// PORTS
//  clk        in   1              single clock
//  rst        in   1              synchronous, active-high reset
//  stride     in   $clog2(KMER_LEN)+1  k-mer stride; sampled on the first word of each sequence; 0 treated as 1
//  in_data    in   WORD_W         packed bases; MSB base is first in sequence order
//  in_valid   in   1              input word valid
//  in_last    in   1              word is the final word of the sequence
//  in_ready   out  1              block can accept a word
//  out_kmer   out  KMER_W         k-mer; MSB base = oldest (first) base
//  out_index  out  IDX_W          sequence position of the k-mer's first base
//  out_last   out  1              final k-mer of the sequence
//  out_valid  out  1              output valid
//  out_ready  in   1              hasher accepts output
//  short_seq  out  1              1-cycle pulse: sequence ended with fewer than KMER_LEN bases
// BEHAVIOUR
//  Reset: in_ready=1; out_valid=0; out_last=0; short_seq=0; out_kmer=0; out_index=0.
//   Window, fill count, position, stride counter and staging are cleared.
//   Reset mid-sequence discards all partial data; no out_last is produced for that sequence.
//  Input handshake: a word transfers on in_valid&&in_ready. It is stored in a staging register with BPW bases.
//  in_ready = staging empty OR (exactly one base left in staging AND it shifts this cycle).
//   This gives back-to-back words at 1 base/cycle.
//  Shift: one base per cycle moves from staging into the window when staging is non-empty and
//   (out_valid==0 OR out_ready==1). Otherwise the pipeline holds and all outputs stay stable.
//  Window: shift register of KMER_LEN bases. fill saturates at KMER_LEN. pos = index of the newest base.
//  Emit: on a shift with fill (after the shift) == KMER_LEN, with candidate start s = pos-KMER_LEN+1:
//   emit when s mod stride == 0, tracked by a stride counter that resets to 0 at sequence start, OR
//   when the shifted base is the last base of an in_last word (tail k-mer is always emitted, out_last=1).
//   Emitted k-mer loads out_kmer/out_index/out_last and sets out_valid on the same edge.
//   Latency: word accepted at edge N -> first base shifted at N+1 -> out_valid seen after N+1.
//  Output handshake: out_valid holds until out_ready. Data must not change while out_valid && !out_ready.
//   out_valid clears on acceptance unless a new k-mer is loaded on the same edge.
//  Sequence end: after the last base of an in_last word shifts, fill, pos and the stride counter clear the same edge.
//   stride is re-sampled on the next accepted word.
//   If fill < KMER_LEN at that point: no k-mer is emitted and short_seq pulses for one cycle.
//  Simultaneous events: acceptance of the old out_kmer and loading of a new one on one edge -> new data, out_valid stays 1.
//  Arithmetic: pos and out_index are IDX_W-bit unsigned and wrap silently.
// TESTING (KMER_LEN=4, BASE_W=4, WORD_W=8, out_ready=1 unless stated)
//  T1 stride=1, bytes 0x12,0x34,0x56(last) -> kmers 0x1234@0, 0x2345@1, 0x3456@2(last); no bubbles after first kmer.
//  T2 stride=2, same bytes -> 0x1234@0, 0x3456@2(last) only.
//  T3 stride=3, same bytes -> 0x1234@0, then tail 0x3456@2 with out_last=1 (forced tail).
//  T4 byte 0x12(last) -> short_seq pulses once, out_valid never asserts; next sequence 0xAB,0xCD(last) -> 0xABCD@0(last).
//  T5 T1 with out_ready low for 5 cycles at the first kmer -> out_kmer=0x1234 stable, in_ready drops, no kmer lost or duplicated.
//  T6 rst asserted after 0x12,0x34 are accepted -> outputs at reset values next cycle; then 0x9A,0xBC(last) -> 0x9ABC@0(last).

Source files
------------

// File: rtl/kmer_window_streamer.sv
// Sliding k-mer front end: unpacks genome words into bases, slides a KMER_LEN window
// over each sequence and hands strided k-mers (plus a forced tail k-mer) to the hasher.
module kmer_window_streamer #(
  parameter int WORD_W   = 8,
  parameter int BASE_W   = 4,
  parameter int KMER_LEN = 4,
  parameter int IDX_W    = 16,
  localparam int SW      = $clog2(KMER_LEN) + 1,
  localparam int KMER_W  = KMER_LEN * BASE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW-1:0]     stride,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [KMER_W-1:0] out_kmer,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              short_seq
);

  localparam int BPW = WORD_W / BASE_W;
  localparam int CW  = $clog2(BPW + 1);
  localparam int FW  = $clog2(KMER_LEN + 1);

  logic [WORD_W-1:0] stage_q, stage_d;
  logic [CW-1:0]     stage_cnt_q, stage_cnt_d;
  logic              stage_last_q, stage_last_d;
  logic [KMER_W-1:0] win_q, win_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [IDX_W-1:0]  nxt_pos_q, nxt_pos_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [SW-1:0]     stride_q, stride_d;
  logic              first_q, first_d;
  logic [KMER_W-1:0] kmer_q, kmer_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              short_q, short_d;

  logic [BASE_W-1:0] base;
  logic              shift_en;
  logic              ready_c;
  logic              accept;
  logic              last_base;
  logic [FW-1:0]     fill_inc;
  logic              full_new;
  logic              emit;

  always_comb begin
    base      = stage_q[WORD_W-1 -: BASE_W];
    shift_en  = (stage_cnt_q != '0) && (!valid_q || out_ready);
    ready_c   = (stage_cnt_q == '0) || ((stage_cnt_q == CW'(1)) && shift_en);
    accept    = in_valid && ready_c;
    last_base = shift_en && (stage_cnt_q == CW'(1)) && stage_last_q;
    fill_inc  = (fill_q == FW'(KMER_LEN)) ? fill_q : fill_q + FW'(1);
    full_new  = (fill_inc == FW'(KMER_LEN));
    emit      = shift_en && full_new && ((scnt_q == '0) || last_base);
  end

  always_comb begin
    stage_d      = stage_q;
    stage_cnt_d  = stage_cnt_q;
    stage_last_d = stage_last_q;
    win_d        = win_q;
    fill_d       = fill_q;
    nxt_pos_d    = nxt_pos_q;
    scnt_d       = scnt_q;
    stride_d     = stride_q;
    first_d      = first_q;
    kmer_d       = kmer_q;
    index_d      = index_q;
    last_d       = last_q;
    valid_d      = valid_q;
    short_d      = 1'b0;

    if (shift_en) begin
      win_d     = {win_q[KMER_W-BASE_W-1:0], base};
      fill_d    = fill_inc;
      nxt_pos_d = nxt_pos_q + IDX_W'(1);
      if (full_new)
        scnt_d = (scnt_q + SW'(1) == stride_q) ? '0 : scnt_q + SW'(1);
    end

    if (last_base) begin
      fill_d    = '0;
      nxt_pos_d = '0;
      scnt_d    = '0;
      first_d   = 1'b1;
      short_d   = !full_new;
    end

    // A word accepted while the previous sequence's last base shifts starts a new sequence.
    if (accept) begin
      stage_d      = in_data;
      stage_cnt_d  = CW'(BPW);
      stage_last_d = in_last;
      first_d      = 1'b0;
      if (first_q || last_base)
        stride_d = (stride == '0) ? SW'(1) : stride;
    end else if (shift_en) begin
      stage_d     = stage_q << BASE_W;
      stage_cnt_d = stage_cnt_q - CW'(1);
    end

    if (emit) begin
      kmer_d  = win_d;
      index_d = nxt_pos_q - IDX_W'(KMER_LEN - 1);
      last_d  = last_base;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      stage_cnt_q  <= '0;
      stage_last_q <= 1'b0;
      win_q        <= '0;
      fill_q       <= '0;
      nxt_pos_q    <= '0;
      scnt_q       <= '0;
      stride_q     <= SW'(1);
      first_q      <= 1'b1;
      kmer_q       <= '0;
      index_q      <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      stage_cnt_q  <= stage_cnt_d;
      stage_last_q <= stage_last_d;
      win_q        <= win_d;
      fill_q       <= fill_d;
      nxt_pos_q    <= nxt_pos_d;
      scnt_q       <= scnt_d;
      stride_q     <= stride_d;
      first_q      <= first_d;
      kmer_q       <= kmer_d;
      index_q      <= index_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      short_q      <= short_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_kmer  = kmer_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign short_seq = short_q;

endmodule

// File: tb/tb_kmer_window_streamer.sv
// Scoreboard bench for kmer_window_streamer: directed sequences plus randomized sequences,
// strides and output backpressure, checked against a base-list reference model.
module tb_kmer_window_streamer;

  localparam int WORD_W = 8, BASE_W = 4, K = 4, IDX_W = 16, SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [SW-1:0]     stride;
  logic [WORD_W-1:0] in_data;
  logic              in_valid, in_last, in_ready;
  logic [15:0]       out_kmer;
  logic [IDX_W-1:0]  out_index;
  logic              out_last, out_valid, out_ready, short_seq;

  kmer_window_streamer #(.WORD_W(WORD_W), .BASE_W(BASE_W), .KMER_LEN(K), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .stride(stride), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_kmer(out_kmer), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .short_seq(short_seq));

  always #5 clk = ~clk;

  typedef struct {bit is_short; logic [15:0] kmer; logic [15:0] idx; bit last;} exp_t;
  exp_t sb[$];
  int vectors = 0, errors = 0;
  bit rand_ready = 0;
  bit hold_v = 0;
  logic [15:0] hk, hi;
  logic hl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list every base, then every start s in [0, n-K]; keep strided starts and the tail.
  task automatic model_seq(input logic [7:0] words[$], input logic [SW-1:0] st);
    int bases[$];
    int n, eff;
    exp_t e;
    foreach (words[i]) begin
      bases.push_back(int'(words[i][7:4]));
      bases.push_back(int'(words[i][3:0]));
    end
    n = bases.size();
    eff = (st == 0) ? 1 : int'(st);
    if (n < K) begin
      e = '{1'b1, 16'h0, 16'h0, 1'b0};
      sb.push_back(e);
    end else begin
      for (int s = 0; s <= n - K; s++) begin
        if ((s % eff) == 0 || s == n - K) begin
          e.is_short = 1'b0;
          e.kmer = 16'(bases[s] * 4096 + bases[s+1] * 256 + bases[s+2] * 16 + bases[s+3]);
          e.idx = 16'(s);
          e.last = (s == n - K);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic send_seq(input logic [7:0] words[$], input logic [SW-1:0] st,
                          input bit terminate, input bit gaps);
    int t;
    stride = st;
    if (terminate) model_seq(words, st);
    foreach (words[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_data  = words[i];
      in_last  = terminate && (i == words.size() - 1);
      in_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 300) begin
          check("in_ready_timeout", 32'(in_ready), 32'd1);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 0;
    end else begin
      if (short_seq) begin
        if (sb.size() == 0) begin
          errors++; vectors++;
          $display("FAIL unexpected_short_seq: got short_seq=1 expected no event");
        end else begin
          e = sb.pop_front();
          check("short_seq_event", 32'(e.is_short), 32'd1);
        end
      end
      if (out_valid && hold_v) begin
        check("stall_kmer_stable", 32'(out_kmer), 32'(hk));
        check("stall_index_stable", 32'(out_index), 32'(hi));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          errors++; vectors++;
          $display("FAIL unexpected_kmer: got %0h@%0d expected none", out_kmer, out_index);
        end else begin
          e = sb.pop_front();
          check("kmer_is_not_short", 32'(e.is_short), 32'd0);
          check("out_kmer", 32'(out_kmer), 32'(e.kmer));
          check("out_index", 32'(out_index), 32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      hold_v = out_valid && !out_ready;
      hk = out_kmer; hi = out_index; hl = out_last;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_short_seq", 32'(short_seq), 32'd0);
    check("rst_out_kmer", 32'(out_kmer), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
  endtask

  logic [7:0] w[$];
  bit saw_stall;

  initial begin
    rst = 1'b1; stride = 1; in_data = 0; in_valid = 0; in_last = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // T1 with back-to-back output check
    w = '{8'h12, 8'h34, 8'h56};
    fork
      send_seq(w, 3'd1, 1'b1, 1'b0);
      begin
        int t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        check("t1_no_bubble_1", {out_valid, out_kmer}, {1'b1, 16'h2345});
        @(negedge clk);
        check("t1_no_bubble_2", {out_valid, out_kmer}, {1'b1, 16'h3456});
      end
    join
    drain();

    send_seq(w, 3'd2, 1'b1, 1'b0); drain();   // T2
    send_seq(w, 3'd3, 1'b1, 1'b0); drain();   // T3

    // T4
    w = '{8'h12};
    send_seq(w, 3'd1, 1'b1, 1'b0);
    w = '{8'hAB, 8'hCD};
    send_seq(w, 3'd1, 1'b1, 1'b0); drain();

    // T5
    out_ready = 1'b0;
    saw_stall = 0;
    w = '{8'h12, 8'h34, 8'h56};
    fork
      send_seq(w, 3'd1, 1'b1, 1'b0);
      begin
        int t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        repeat (5) begin
          @(negedge clk);
          check("t5_stalled_kmer", 32'(out_kmer), 32'h1234);
          if (!in_ready) saw_stall = 1;
        end
        check("t5_in_ready_dropped", 32'(saw_stall), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // T6
    w = '{8'h12, 8'h34};
    send_seq(w, 3'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;
    w = '{8'h9A, 8'hBC};
    send_seq(w, 3'd1, 1'b1, 1'b0); drain();

    // Randomized sequences, strides and backpressure
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(1, 8);
      w = {};
      for (int i = 0; i < len; i++) w.push_back(8'($urandom));
      send_seq(w, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
    end
    drain();
    rand_ready = 0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
